// File: rtl/instr_decoder.sv
// instr_decoder: single-cycle registered instruction decoder (pipeline stage 1).
// Opcode r_in[31:25] selects one register-write enable or instruction strobe;
// immediate and control fields are extracted per opcode, all others forced to 0.
// Optional macro INSTR_DECODER_ILLEGAL_EN adds a registered 'illegal' flag for op 45-127.
module instr_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] r_in,
  output logic [7:0]  xbh_en,
  output logic [7:0]  xbl_en,
  output logic [7:0]  fir_reg_en,
  output logic [1:0]  des_addr_en,
  output logic [1:0]  sor_addr_en,
  output logic        len_en,
  output logic [3:0]  lr_en,
  output logic [3:0]  hr_en,
  output logic [15:0] operand,
  output logic        ad_en,
  output logic        xb_en,
  output logic        fir_en,
  output logic        uarto_en,
  output logic        zlb_en,
  output logic        move_en,
  output logic        int_en,
  output logic        jc_en,
  output logic        des,
  output logic [7:0]  select,
  output logic [7:0]  channel,
  output logic [1:0]  source,
  output logic        dir
`ifdef INSTR_DECODER_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  localparam int unsigned OP_W = 7;

  logic [OP_W-1:0] op;
  logic [5:0]      unused_bits;

  logic [7:0]  xbh_en_nxt;
  logic [7:0]  xbl_en_nxt;
  logic [7:0]  fir_reg_en_nxt;
  logic [1:0]  des_addr_en_nxt;
  logic [1:0]  sor_addr_en_nxt;
  logic        len_en_nxt;
  logic [3:0]  lr_en_nxt;
  logic [3:0]  hr_en_nxt;
  logic [15:0] operand_nxt;
  logic        ad_en_nxt;
  logic        xb_en_nxt;
  logic        fir_en_nxt;
  logic        uarto_en_nxt;
  logic        zlb_en_nxt;
  logic        move_en_nxt;
  logic        int_en_nxt;
  logic        jc_en_nxt;
  logic        des_nxt;
  logic [7:0]  select_nxt;
  logic [7:0]  channel_nxt;
  logic [1:0]  source_nxt;
  logic        dir_nxt;

  assign op          = r_in[31:25];
  assign unused_bits = r_in[24:19];

  // Opcode decode: one enable bit plus the fields that opcode consumes
  always_comb begin
    xbh_en_nxt      = '0;
    xbl_en_nxt      = '0;
    fir_reg_en_nxt  = '0;
    des_addr_en_nxt = '0;
    sor_addr_en_nxt = '0;
    len_en_nxt      = 1'b0;
    lr_en_nxt       = '0;
    hr_en_nxt       = '0;
    operand_nxt     = '0;
    ad_en_nxt       = 1'b0;
    xb_en_nxt       = 1'b0;
    fir_en_nxt      = 1'b0;
    uarto_en_nxt    = 1'b0;
    zlb_en_nxt      = 1'b0;
    move_en_nxt     = 1'b0;
    int_en_nxt      = 1'b0;
    jc_en_nxt       = 1'b0;
    des_nxt         = 1'b0;
    select_nxt      = '0;
    channel_nxt     = '0;
    source_nxt      = '0;
    dir_nxt         = 1'b0;

    // Register-write opcodes 0-36 carry the 16-bit immediate
    if (op <= OP_W'(36)) begin
      operand_nxt = r_in[15:0];
    end

    if (op < OP_W'(8)) begin
      xbh_en_nxt[op[2:0]] = 1'b1;
    end else if (op < OP_W'(16)) begin
      xbl_en_nxt[op[2:0]] = 1'b1;
    end else if (op < OP_W'(24)) begin
      fir_reg_en_nxt[op[2:0]] = 1'b1;
    end else if (op < OP_W'(26)) begin
      des_addr_en_nxt[op[0]] = 1'b1;
    end else if (op < OP_W'(28)) begin
      sor_addr_en_nxt[op[0]] = 1'b1;
    end else if (op == OP_W'(28)) begin
      len_en_nxt = 1'b1;
    end else if (op < OP_W'(33)) begin
      lr_en_nxt[2'(op - OP_W'(29))] = 1'b1;
    end else if (op < OP_W'(37)) begin
      hr_en_nxt[2'(op - OP_W'(33))] = 1'b1;
    end

    case (op)
      OP_W'(37): begin
        ad_en_nxt  = 1'b1;
        des_nxt    = r_in[18];
        select_nxt = r_in[7:0];
      end
      OP_W'(38): begin
        xb_en_nxt   = 1'b1;
        select_nxt  = r_in[7:0];
        channel_nxt = r_in[15:8];
        source_nxt  = r_in[17:16];
      end
      OP_W'(39): begin
        fir_en_nxt  = 1'b1;
        select_nxt  = r_in[7:0];
        channel_nxt = r_in[15:8];
        source_nxt  = r_in[17:16];
      end
      OP_W'(40): begin
        uarto_en_nxt = 1'b1;
        select_nxt   = r_in[7:0];
        channel_nxt  = r_in[15:8];
        source_nxt   = r_in[17:16];
      end
      OP_W'(41): begin
        zlb_en_nxt = 1'b1;
        source_nxt = r_in[17:16];
      end
      OP_W'(42): begin
        move_en_nxt = 1'b1;
        dir_nxt     = r_in[18];
      end
      OP_W'(43): begin
        int_en_nxt = 1'b1;
      end
      OP_W'(44): begin
        jc_en_nxt   = 1'b1;
        channel_nxt = r_in[15:8];
      end
      default: begin
      end
    endcase
  end

  // Output registers: one-cycle latency, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xbh_en      <= '0;
      xbl_en      <= '0;
      fir_reg_en  <= '0;
      des_addr_en <= '0;
      sor_addr_en <= '0;
      len_en      <= 1'b0;
      lr_en       <= '0;
      hr_en       <= '0;
      operand     <= '0;
      ad_en       <= 1'b0;
      xb_en       <= 1'b0;
      fir_en      <= 1'b0;
      uarto_en    <= 1'b0;
      zlb_en      <= 1'b0;
      move_en     <= 1'b0;
      int_en      <= 1'b0;
      jc_en       <= 1'b0;
      des         <= 1'b0;
      select      <= '0;
      channel     <= '0;
      source      <= '0;
      dir         <= 1'b0;
    end else begin
      xbh_en      <= xbh_en_nxt;
      xbl_en      <= xbl_en_nxt;
      fir_reg_en  <= fir_reg_en_nxt;
      des_addr_en <= des_addr_en_nxt;
      sor_addr_en <= sor_addr_en_nxt;
      len_en      <= len_en_nxt;
      lr_en       <= lr_en_nxt;
      hr_en       <= hr_en_nxt;
      operand     <= operand_nxt;
      ad_en       <= ad_en_nxt;
      xb_en       <= xb_en_nxt;
      fir_en      <= fir_en_nxt;
      uarto_en    <= uarto_en_nxt;
      zlb_en      <= zlb_en_nxt;
      move_en     <= move_en_nxt;
      int_en      <= int_en_nxt;
      jc_en       <= jc_en_nxt;
      des         <= des_nxt;
      select      <= select_nxt;
      channel     <= channel_nxt;
      source      <= source_nxt;
      dir         <= dir_nxt;
    end
  end

`ifdef INSTR_DECODER_ILLEGAL_EN
  logic illegal_nxt;

  assign illegal_nxt = (op > OP_W'(44));

  // Illegal-opcode flag, same latency as the decode outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else begin
      illegal <= illegal_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: scoreboard bench for instr_decoder. Stimulus pushes the
// expected decode of each word; a monitor pops and compares one cycle later.
module tb_instr_decoder;

  typedef struct packed {
    logic [44:0] en;
    logic [15:0] operand;
    logic [7:0]  select;
    logic [7:0]  channel;
    logic [1:0]  source;
    logic        des;
    logic        dir;
    logic        illegal;
  } out_t;

`ifdef INSTR_DECODER_ILLEGAL_EN
  localparam bit HAS_ILL = 1'b1;
`else
  localparam bit HAS_ILL = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] r_in;
  logic [7:0]  xbh_en, xbl_en, fir_reg_en;
  logic [1:0]  des_addr_en, sor_addr_en;
  logic        len_en;
  logic [3:0]  lr_en, hr_en;
  logic [15:0] operand;
  logic        ad_en, xb_en, fir_en, uarto_en, zlb_en, move_en, int_en, jc_en;
  logic        des;
  logic [7:0]  select, channel;
  logic [1:0]  source;
  logic        dir;
  logic        illegal_s;

  int checks = 0;
  int errors = 0;

  out_t  exp_q[$];
  string name_q[$];

  instr_decoder dut (
    .clk(clk), .rst_n(rst_n), .r_in(r_in),
    .xbh_en(xbh_en), .xbl_en(xbl_en), .fir_reg_en(fir_reg_en),
    .des_addr_en(des_addr_en), .sor_addr_en(sor_addr_en), .len_en(len_en),
    .lr_en(lr_en), .hr_en(hr_en), .operand(operand),
    .ad_en(ad_en), .xb_en(xb_en), .fir_en(fir_en), .uarto_en(uarto_en),
    .zlb_en(zlb_en), .move_en(move_en), .int_en(int_en), .jc_en(jc_en),
    .des(des), .select(select), .channel(channel), .source(source), .dir(dir)
`ifdef INSTR_DECODER_ILLEGAL_EN
    , .illegal(illegal_s)
`endif
  );

`ifndef INSTR_DECODER_ILLEGAL_EN
  assign illegal_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t o;
    o.en = {jc_en, int_en, move_en, zlb_en, uarto_en, fir_en, xb_en, ad_en,
            hr_en, lr_en, len_en, sor_addr_en, des_addr_en, fir_reg_en, xbl_en, xbh_en};
    o.operand = operand;
    o.select  = select;
    o.channel = channel;
    o.source  = source;
    o.des     = des;
    o.dir     = dir;
    o.illegal = illegal_s;
    return o;
  endfunction

  // idx is the flat enable position (equals the opcode); -1 for none
  function automatic out_t mk(int idx, logic [15:0] opd, logic [7:0] sel, logic [7:0] ch,
                              logic [1:0] src, logic d, logic dr, logic ill);
    out_t o;
    o = '0;
    if (idx >= 0) o.en = 45'(1) << idx;
    o.operand = opd;
    o.select  = sel;
    o.channel = ch;
    o.source  = src;
    o.des     = d;
    o.dir     = dr;
    o.illegal = ill & HAS_ILL;
    return o;
  endfunction

  task automatic compare(string nm, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got en=%h opd=%h sel=%h ch=%h src=%b des=%b dir=%b ill=%b, want en=%h opd=%h sel=%h ch=%h src=%b des=%b dir=%b ill=%b",
               nm, act.en, act.operand, act.select, act.channel, act.source, act.des, act.dir, act.illegal,
               exp.en, exp.operand, exp.select, exp.channel, exp.source, exp.des, exp.dir, exp.illegal);
    end
  endtask

  task automatic issue(string nm, logic [31:0] w, out_t e);
    @(negedge clk);
    r_in = w;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every decoded cycle out of reset consumes one expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        compare(name_q.pop_front(), sample(), exp_q.pop_front());
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    logic [6:0]  op;
    logic [15:0] opd;
    logic [7:0]  sel, ch;
    logic [1:0]  src;

    rst_n = 1'b0;
    r_in  = 32'h44C7D916;
    repeat (3) @(posedge clk);
    #1 compare("reset_zero", sample(), '0);

    // Release: first edge decodes op 34
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(mk(34, 16'hD916, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0));
    name_q.push_back("release_op34");

    issue("op0",  32'h01AAA75C, mk(0,  16'hA75C, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0));
    issue("op1",  32'h0325456B, mk(1,  16'h456B, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0));
    issue("op37", 32'h4AB6430E, mk(37, 16'h0000, 8'h0E, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0));
    issue("op40", 32'h5160D7AB, mk(40, 16'h0000, 8'hAB, 8'hD7, 2'b00, 1'b0, 1'b0, 1'b0));
    issue("op42", 32'h55E5796E, mk(42, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0));
    issue("op45", 32'h5A000000, mk(-1, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1));
    issue("op38", 32'h4C063C5A, mk(38, 16'h0000, 8'h5A, 8'h3C, 2'b10, 1'b0, 1'b0, 1'b0));
    issue("op41", 32'h5203FFFF, mk(41, 16'h0000, 8'h00, 8'h00, 2'b11, 1'b0, 1'b0, 1'b0));
    issue("op44", 32'h5800AB12, mk(44, 16'h0000, 8'h00, 8'hAB, 2'b00, 1'b0, 1'b0, 1'b0));
    issue("op28_len", 32'h38001234, mk(28, 16'h1234, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0));
    // Held instruction: strobe repeats every cycle
    for (int i = 0; i < 3; i++)
      issue("op43_hold", 32'h56000000, mk(43, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0));
    issue("op127", 32'hFFFFFFFF, mk(-1, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1));

    // Sweep all opcodes with every low bit set, plus some illegal ones
    for (int k = 0; k < 48; k++) begin
      op  = 7'(k);
      opd = (k <= 36) ? 16'hFFFF : 16'h0000;
      sel = (k >= 37 && k <= 40) ? 8'hFF : 8'h00;
      ch  = (k == 38 || k == 39 || k == 40 || k == 44) ? 8'hFF : 8'h00;
      src = (k >= 38 && k <= 41) ? 2'b11 : 2'b00;
      issue("sweep", {op, 25'h1FFFFFF},
            mk((k <= 44) ? k : -1, opd, sel, ch, src, (k == 37), (k == 42), (k > 44)));
    end
    issue("op64", 32'h80000000, mk(-1, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1));
    issue("op2_after_ill", 32'h0400BEEF, mk(2, 16'hBEEF, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0));
    drain();

    // Mid-stream async reset drops the pending decode and clears outputs now
    issue("pre_reset_op37", 32'h4A04000F, mk(37, 16'h0000, 8'h0F, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0));
    drain();
    @(negedge clk);
    r_in = 32'h01AAA75C;
    #1 rst_n = 1'b0;
    #1 compare("async_reset", sample(), '0);
    @(posedge clk);
    #1 compare("reset_hold", sample(), '0);
    @(negedge clk);
    r_in  = 32'h4C063C5A;
    rst_n = 1'b1;
    exp_q.push_back(mk(38, 16'h0000, 8'h5A, 8'h3C, 2'b10, 1'b0, 1'b0, 1'b0));
    name_q.push_back("post_reset_op38");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
